datamem_vec_banked: RTL and testbench

DATAMEM_VEC_BANKED -- requirements
Module: datamem_vec_banked

---
 rtl/datamem_vec_banked.sv | 261 ++++++++++++++++++++++++++
 tb/tb_datamem_vec_banked.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/datamem_vec_banked.sv
// -----------------------------------------------------------------------------
// datamem_vec_banked
//   Vector data memory split into LANES single-port banks. Word w of the
//   global address space lives in bank (w mod LANES) at row (w / LANES).
//   A request carries one byte address per lane. Every active lane is
//   serviced through its bank. Lanes that collide on a bank are serialised,
//   lowest lane index first.
//
// Parameters
//   LANES    number of 32-bit lanes and of banks (power of two, 1..8)
//   DEPTH    total 32-bit words (multiple of LANES)
//   INIT_AES preload the AES-128 constant table at elaboration
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (array contents are kept)
//   req_valid  request present
//   req_ready  block idle and able to accept
//   vector     1: lanes per vmask, 0: lane 0 only
//   we         1111 word / 0011 half / 0001 byte store, anything else reads
//   vmask      per-lane enable (vector requests only)
//   addr       per-lane byte address, lane i in [32i+31:32i]
//   datain     per-lane store data, same packing
//   rsp_valid  one-cycle completion pulse
//   dataout    per-lane load data, valid with rsp_valid
//   err        some active lane addressed a word >= DEPTH
// -----------------------------------------------------------------------------
module datamem_vec_banked #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 128,
  parameter bit INIT_AES = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  vector,
  input  logic [3:0]            we,
  input  logic [LANES-1:0]      vmask,
  input  logic [32*LANES-1:0]   addr,
  input  logic [32*LANES-1:0]   datain,
  output logic                  rsp_valid,
  output logic [32*LANES-1:0]   dataout,
  output logic                  err
);

  localparam int ROWS = DEPTH / LANES;
  localparam int BW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef logic [LANES-1:0][ROWS-1:0][31:0] mem_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  // Global word -> preload value.
  function automatic logic [31:0] aes_word(input int w);
    case (w)
      'h00: aes_word = 32'h0000_0001;
      'h01: aes_word = 32'h0000_0002;
      'h02: aes_word = 32'h0000_0004;
      'h03: aes_word = 32'h0000_0008;
      'h04: aes_word = 32'h0000_0010;
      'h05: aes_word = 32'h0000_0020;
      'h06: aes_word = 32'h0000_0040;
      'h07: aes_word = 32'h0000_0080;
      'h08: aes_word = 32'h0000_001b;
      'h09: aes_word = 32'h0000_0036;
      'h0a: aes_word = 32'h5349_5459;
      'h0b: aes_word = 32'h4956_4552;
      'h0c: aes_word = 32'h4920_554e;
      'h0d: aes_word = 32'h484f_5345;
      'h12: aes_word = 32'h2a23_88a0;
      'h13: aes_word = 32'h6ca3_54fa;
      'h14: aes_word = 32'h7639_2cfe;
      'h15: aes_word = 32'h0539_b117;
      default: aes_word = 32'h0;
    endcase
  endfunction

  function automatic mem_t init_mem();
    mem_t m;
    m = '0;
    if (INIT_AES) begin
      for (int w = 0; w < DEPTH; w++) begin
        m[BW'(w % LANES)][RW'(w / LANES)] = aes_word(w);
      end
    end
    return m;
  endfunction

  // Byte enables of a store; all-zero for reads and unknown codes.
  function automatic logic [3:0] store_be(input logic [3:0] w, input logic [1:0] off);
    case (w)
      4'b1111: store_be = 4'b1111;
      4'b0011: store_be = off[1] ? 4'b1100 : 4'b0011;
      4'b0001: store_be = 4'b0001 << off;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated so every byte enable sees the right byte.
  function automatic logic [31:0] store_data(input logic [3:0] w, input logic [31:0] d);
    case (w)
      4'b0011: store_data = {2{d[15:0]}};
      4'b0001: store_data = {4{d[7:0]}};
      default: store_data = d;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                      state_q;
  logic [LANES-1:0]            pending_q;
  logic [3:0]                  we_q;
  logic [LANES-1:0][31:0]      addr_q;
  logic [LANES-1:0][31:0]      datain_q;
  logic [LANES-1:0][31:0]      dataout_q;
  logic                        rsp_valid_q;
  logic                        err_q;

  mem_t mem_q = init_mem();

  // ---------------------------------------------------------------------------
  // Lane decode and bank arbitration
  // ---------------------------------------------------------------------------
  logic [LANES-1:0][29:0]      lane_word;
  logic [LANES-1:0][BW-1:0]    lane_bank;
  logic [LANES-1:0][RW-1:0]    lane_row;
  logic [LANES-1:0]            lane_ok;
  logic [LANES-1:0]            served;
  logic [LANES-1:0]            pending_d;
  logic                        is_store;

  logic [LANES-1:0]            bank_en;
  logic [LANES-1:0][RW-1:0]    bank_row;
  logic [LANES-1:0][3:0]       bank_be;
  logic [LANES-1:0][31:0]      bank_wdata;
  logic [LANES-1:0][31:0]      bank_rdata;

  assign is_store = (we_q == 4'b1111) || (we_q == 4'b0011) || (we_q == 4'b0001);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_word[i] = addr_q[i][31:2];
      lane_bank[i] = BW'(lane_word[i] % 30'(LANES));
      lane_row[i]  = RW'(lane_word[i] / 30'(LANES));
      lane_ok[i]   = lane_word[i] < 30'(DEPTH);
    end
  end

  // A pending lane is served this cycle unless a lower-index pending lane
  // targets the same bank. Out-of-range lanes still take their bank slot.
  always_comb begin
    served = pending_q;
    for (int i = 1; i < LANES; i++) begin
      for (int j = 0; j < i; j++) begin
        if (pending_q[j] && (lane_bank[j] == lane_bank[i])) served[i] = 1'b0;
      end
    end
    pending_d = pending_q & ~served;
  end

  // At most one served lane maps to each bank, so this steering never merges.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    bank_en    = '0;
    bank_row   = '0;
    bank_be    = '0;
    bank_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (served[i] && lane_ok[i]) begin
        bank_en[lane_bank[i]]    = 1'b1;
        bank_row[lane_bank[i]]   = lane_row[i];
        bank_be[lane_bank[i]]    = store_be(we_q, addr_q[i][1:0]);
        bank_wdata[lane_bank[i]] = store_data(we_q, datain_q[i]);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      bank_rdata[b] = mem_q[b][bank_row[b]];
    end
  end

  // ---------------------------------------------------------------------------
  // Bank arrays
  // ---------------------------------------------------------------------------
  // NOTE: the arrays are deliberately left out of reset; a reset mid-request
  // keeps whatever earlier cycles already committed. Writes are blocked in the
  // reset cycle itself so an aborted request stops short.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ISSUE) begin
      for (int b = 0; b < LANES; b++) begin
        for (int k = 0; k < 4; k++) begin
          if (bank_en[b] && bank_be[b][k]) begin
            mem_q[b][bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      we_q        <= '0;
      addr_q      <= '0;
      datain_q    <= '0;
      dataout_q   <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (req_valid) begin
            we_q      <= we;
            addr_q    <= addr;
            datain_q  <= datain;
            pending_q <= vector ? vmask : LANES'(1);
            dataout_q <= '0;
            err_q     <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          pending_q <= pending_d;
          if (|(served & ~lane_ok)) err_q <= 1'b1;
          for (int i = 0; i < LANES; i++) begin
            if (served[i] && lane_ok[i] && !is_store) begin
              dataout_q[i] <= bank_rdata[lane_bank[i]];
            end
          end
          if (pending_d == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign dataout   = dataout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_datamem_vec_banked.sv
// -----------------------------------------------------------------------------
// tb_datamem_vec_banked
//   Directed bench for datamem_vec_banked with LANES=4, DEPTH=128 and the
//   AES preload. Inputs change on the falling edge, outputs are sampled on
//   the falling edge. Latency is counted in cycles from the accept cycle T.
// -----------------------------------------------------------------------------
module tb_datamem_vec_banked;

  localparam int LANES = 4;
  localparam int W     = 32 * LANES;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic           vector;
  logic [3:0]     we;
  logic [LANES-1:0] vmask;
  logic [W-1:0]   addr;
  logic [W-1:0]   datain;
  logic           rsp_valid;
  logic [W-1:0]   dataout;
  logic           err;

  int total = 0;
  int bad   = 0;

  datamem_vec_banked #(
    .LANES   (LANES),
    .DEPTH   (128),
    .INIT_AES(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .vector   (vector),
    .we       (we),
    .vmask    (vmask),
    .addr     (addr),
    .datain   (datain),
    .rsp_valid(rsp_valid),
    .dataout  (dataout),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] v4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request: issue at the current falling edge, wait (bounded) for
  // the response, check latency / data / err, then check the pulse ends.
  task automatic txn(input string tag, input logic vec, input logic [3:0] w,
                     input logic [LANES-1:0] m, input logic [W-1:0] a,
                     input logic [W-1:0] d, input int exp_lat,
                     input logic [W-1:0] exp_do, input logic exp_err);
    int  c;
    bit  got;
    req_valid = 1'b1;
    vector    = vec;
    we        = w;
    vmask     = m;
    addr      = a;
    datain    = d;
    check({tag, " ready"}, W'(req_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs: the block must work from its latched copy.
    req_valid = 1'b0;
    vector    = ~vec;
    we        = 4'b1111;
    vmask     = ~m;
    addr      = ~a;
    datain    = ~d;
    c   = 1;
    got = 1'b0;
    while (!got && c <= 20) begin
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
        c++;
      end
    end
    check({tag, " latency"}, W'(c), W'(exp_lat));
    check({tag, " dataout"}, dataout, exp_do);
    check({tag, " err"}, W'(err), W'(exp_err));
    @(posedge clk);
    @(negedge clk);
    check({tag, " pulse end"}, W'({rsp_valid, req_ready}), W'(2'b01));
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    req_valid = 1'b0;
    vector    = 1'b0;
    we        = 4'b0000;
    vmask     = '0;
    addr      = '0;
    datain    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", W'(req_ready), W'(0));
    check("reset rsp_valid", W'(rsp_valid), W'(0));
    check("reset err", W'(err), W'(0));
    check("reset dataout", dataout, '0);
    rst = 1'b0;
    #1;
    check("post-reset ready", W'(req_ready), W'(1));
    @(negedge clk);

    // Conflict-free vector load of the key words 0x0a..0x0d
    txn("vload key", 1'b1, 4'b0000, 4'b1111, v4(32'h28, 32'h2c, 32'h30, 32'h34), '0,
        2, v4(32'h5349_5459, 32'h4956_4552, 32'h4920_554e, 32'h484f_5345), 1'b0);

    // Four lanes all in bank 0: words 0, 4, 8, 12
    txn("vload bank0", 1'b1, 4'b0000, 4'b1111, v4(32'h00, 32'h10, 32'h20, 32'h30), '0,
        5, v4(32'h0000_0001, 32'h0000_0010, 32'h0000_001b, 32'h4920_554e), 1'b0);

    // Empty active set
    txn("empty set", 1'b1, 4'b0000, 4'b0000, v4(32'h00, 32'h04, 32'h08, 32'h0c), '0,
        2, '0, 1'b0);

    // Scalar byte store into word 0x0a byte 1; other lanes must stay idle
    txn("byte store", 1'b0, 4'b0001, 4'b1111, v4(32'h29, 32'h00, 32'h04, 32'h08),
        v4(32'h0000_00ab, 32'hdead_beef, 32'hdead_beef, 32'hdead_beef), 2, '0, 1'b0);
    txn("byte readback", 1'b0, 4'b0000, 4'b1111, v4(32'h28, 32'h2c, 32'h30, 32'h34), '0,
        2, v4(32'h5349_ab59, 32'h0, 32'h0, 32'h0), 1'b0);

    // Halfword store to the upper half of word 0x0b, then an unknown we code
    txn("half store", 1'b0, 4'b0011, 4'b0001, v4(32'h2e, 32'h0, 32'h0, 32'h0),
        v4(32'hffff_1234, 32'h0, 32'h0, 32'h0), 2, '0, 1'b0);
    txn("odd we code", 1'b0, 4'b0111, 4'b0001, v4(32'h2c, 32'h0, 32'h0, 32'h0),
        v4(32'hffff_ffff, 32'h0, 32'h0, 32'h0), 2, v4(32'h1234_4552, 32'h0, 32'h0, 32'h0), 1'b0);
    txn("half readback", 1'b0, 4'b0000, 4'b0001, v4(32'h2c, 32'h0, 32'h0, 32'h0), '0,
        2, v4(32'h1234_4552, 32'h0, 32'h0, 32'h0), 1'b0);

    // Same-word vector store: lanes 0 and 2 hit word 0x10, lanes 1,3 masked
    txn("same-word store", 1'b1, 4'b1111, 4'b0101, v4(32'h40, 32'h44, 32'h40, 32'h4c),
        v4(32'h1111_1111, 32'h3333_3333, 32'h2222_2222, 32'h4444_4444), 3, '0, 1'b0);
    txn("same-word readback", 1'b1, 4'b0000, 4'b1111, v4(32'h40, 32'h44, 32'h4c, 32'h50), '0,
        3, v4(32'h2222_2222, 32'h0, 32'h6ca3_54fa, 32'h7639_2cfe), 1'b0);

    // Range boundary: word 128 is out of range, word 127 is the last one
    txn("oor load", 1'b0, 4'b0000, 4'b0001, v4(32'h200, 32'h0, 32'h0, 32'h0), '0,
        2, '0, 1'b1);
    txn("last word load", 1'b0, 4'b0000, 4'b0001, v4(32'h1fc, 32'h0, 32'h0, 32'h0), '0,
        2, '0, 1'b0);
    txn("oor store", 1'b0, 4'b1111, 4'b0001, v4(32'h200, 32'h0, 32'h0, 32'h0),
        v4(32'hcafe_f00d, 32'h0, 32'h0, 32'h0), 2, '0, 1'b1);
    txn("oor store no alias", 1'b0, 4'b0000, 4'b0001, v4(32'h00, 32'h0, 32'h0, 32'h0), '0,
        2, v4(32'h0000_0001, 32'h0, 32'h0, 32'h0), 1'b0);

    // Reset during the second ISSUE cycle of a 4-way conflicting store
    req_valid = 1'b1;
    vector    = 1'b1;
    we        = 4'b1111;
    vmask     = 4'b1111;
    addr      = v4(32'h80, 32'h90, 32'ha0, 32'hb0);
    datain    = v4(32'ha0a0_a0a0, 32'hb1b1_b1b1, 32'hc2c2_c2c2, 32'hd3d3_d3d3);
    check("abort ready", W'(req_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort issue1 rsp", W'(rsp_valid), W'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort reset ready", W'(req_ready), W'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort after ready", W'(req_ready), W'(1));
    check("abort after dataout", dataout, '0);
    check("abort after err", W'(err), W'(0));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) pulses++;
      @(negedge clk);
    end
    check("abort no response", W'(pulses), W'(0));
    txn("abort readback", 1'b1, 4'b0000, 4'b1111, v4(32'h80, 32'h90, 32'ha0, 32'hb0), '0,
        5, v4(32'ha0a0_a0a0, 32'h0, 32'h0, 32'h0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
